instruction_fetch: RTL and testbench

Instruction fetch stage sitting directly upstream of the R/I/J instruction decoders. It holds the program counter and issues word fetches to instruction memory over a request/response handshake. It buffers up to two returned words with their PCs and presents them to the decode stage over a valid/ready handshake. It accepts PC redirects (branch/jump/jr) from later stages, flushing anything fetched down the wrong path.

---
 rtl/lab3_pkg.sv | 29 ++
 rtl/fetch_buffer.sv | 70 +++++++
 rtl/instruction_fetch.sv | 118 +++++++++++
 tb/tb_instruction_fetch.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lab3_pkg.sv
// Shared types and constants for the instruction fetch stage and its buffer.
package lab3_pkg;

  localparam int WORD_W     = 32;
  localparam int INSN_BYTES = 4;

  localparam logic [WORD_W-1:0] RESET_PC = 32'h0000_0000;

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [WORD_W-1:0] pc;
    logic [WORD_W-1:0] insn;
  } fetch_entry_t;

  // Sequential word address; wraps naturally at 2^32.
  function automatic logic [WORD_W-1:0] pc_next(input logic [WORD_W-1:0] pc);
    return pc + 32'(INSN_BYTES);
  endfunction

  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] pc);
    return pc & ~32'(INSN_BYTES - 1);
  endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Two-entry FIFO of fetched {pc, insn} pairs; head is always the oldest entry.
module fetch_buffer
  import lab3_pkg::*;
(
  input  logic         clk,
  input  logic         reset_n,
  input  logic         push_i,
  input  fetch_entry_t push_entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [1:0]   count_o,
  output fetch_entry_t head_o
);

  fetch_entry_t entry_q [2];
  fetch_entry_t entry_d [2];
  logic         rd_ptr_q, rd_ptr_d;
  logic         wr_ptr_q, wr_ptr_d;
  logic [1:0]   count_q, count_d;
  logic         do_push_s, do_pop_s;

  assign do_pop_s  = pop_i & (count_q != 2'd0);
  assign do_push_s = push_i & ((count_q != 2'd2) | do_pop_s);

  // Next-state for storage, pointers and occupancy; flush only clears bookkeeping.
  always_comb begin
    entry_d  = entry_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = 1'b0;
      wr_ptr_d = 1'b0;
      count_d  = 2'd0;
    end else begin
      if (do_push_s) begin
        entry_d[wr_ptr_q] = push_entry_i;
        wr_ptr_d          = ~wr_ptr_q;
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop_s) begin
        rd_ptr_d = ~rd_ptr_q;
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      count_d = count_q + {1'b0, do_push_s} - {1'b0, do_pop_s};
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      entry_q[0] <= '0;
      entry_q[1] <= '0;
      rd_ptr_q   <= 1'b0;
      wr_ptr_q   <= 1'b0;
      count_q    <= 2'd0;
    end else begin
      entry_q  <= entry_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign count_o = count_q;
  assign head_o  = entry_q[rd_ptr_q];

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC, request/response FSM with redirect flush, and a two-entry
// decode buffer. out_* come only from registers (no path from imem_rdata).
module instruction_fetch
  import lab3_pkg::*;
(
  input  logic              clk,
  input  logic              reset_n,
  output logic              imem_req,
  output logic [WORD_W-1:0] imem_addr,
  input  logic              imem_ready,
  input  logic              imem_rvalid,
  input  logic [WORD_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [WORD_W-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_instruction,
  output logic [WORD_W-1:0] out_pc,
  output logic [WORD_W-1:0] out_pc_plus4
);

  fetch_state_e      state_q, state_d;
  logic [WORD_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [WORD_W-1:0] issued_pc_q, issued_pc_d;
  logic [1:0]        count_s;
  fetch_entry_t      head_s;
  fetch_entry_t      push_entry_s;
  logic              credit_s, req_hs_s, push_s, pop_s;

  // Credit counts buffered words plus the one outstanding request, if any.
  assign credit_s  = ({1'b0, count_s} + {2'b00, (state_q != S_REQ)}) < 3'd2;
  assign imem_req  = reset_n & (state_q == S_REQ) & credit_s;
  assign imem_addr = fetch_pc_q;
  assign req_hs_s  = imem_req & imem_ready;

  assign out_valid = (count_s != 2'd0);
  assign pop_s     = out_valid & out_ready & ~redirect_valid;

  assign push_entry_s = '{pc: issued_pc_q, insn: imem_rdata};

  // Next fetch PC, issued-PC capture and FSM transitions; redirect wins.
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    issued_pc_d = issued_pc_q;
    push_s      = 1'b0;

    if (redirect_valid) begin
      fetch_pc_d = word_align(redirect_pc);
    end else if (req_hs_s) begin
      fetch_pc_d = pc_next(fetch_pc_q);
    end else begin
      fetch_pc_d = fetch_pc_q;
    end

    if (req_hs_s) begin
      issued_pc_d = fetch_pc_q;
    end else begin
      issued_pc_d = issued_pc_q;
    end

    case (state_q)
      S_REQ: begin
        if (req_hs_s) begin
          state_d = redirect_valid ? S_DROP : S_WAIT;
        end else begin
          state_d = S_REQ;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_d = S_REQ;
          push_s  = ~redirect_valid;
        end else if (redirect_valid) begin
          state_d = S_DROP;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_DROP: begin
        state_d = imem_rvalid ? S_REQ : S_DROP;
      end
      default: begin
        state_d = S_REQ;
      end
    endcase
  end

  // FSM and PC registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= S_REQ;
      fetch_pc_q  <= RESET_PC;
      issued_pc_q <= RESET_PC;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      issued_pc_q <= issued_pc_d;
    end
  end

  fetch_buffer u_fetch_buffer (
    .clk          (clk),
    .reset_n      (reset_n),
    .push_i       (push_s),
    .push_entry_i (push_entry_s),
    .pop_i        (pop_s),
    .flush_i      (redirect_valid),
    .count_o      (count_s),
    .head_o       (head_s)
  );

  // Idle outputs read as zero so the decoder never sees stale entries.
  assign out_instruction = out_valid ? head_s.insn : {WORD_W{1'b0}};
  assign out_pc          = out_valid ? head_s.pc : {WORD_W{1'b0}};
  assign out_pc_plus4    = out_valid ? pc_next(head_s.pc) : {WORD_W{1'b0}};

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed scenarios plus a random
// run checked against a program-order model of fetch and decode addresses.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset_n, imem_req, imem_ready, imem_rvalid;
  logic        redirect_valid, out_valid, out_ready;
  logic [31:0] imem_addr, imem_rdata, redirect_pc;
  logic [31:0] out_instruction, out_pc, out_pc_plus4;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat_min = 1, lat_max = 1, ready_pct = 100;
  bit hold_ready = 1'b0;
  logic [31:0] mq_addr[$];
  int          mq_due[$];

  instruction_fetch dut (
    .clk(clk), .reset_n(reset_n), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instruction(out_instruction),
    .out_pc(out_pc), .out_pc_plus4(out_pc_plus4)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] word_at(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  task automatic drive_mem();
    imem_ready = hold_ready ? 1'b0 : (int'($urandom_range(99)) < ready_pct);
    if (mq_addr.size() > 0 && cyc >= mq_due[0]) begin
      imem_rvalid = 1'b1;
      imem_rdata  = word_at(mq_addr[0]);
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
  endtask

  // Memory model bookkeeping at the end of a cycle, then advance one clock.
  task automatic tick();
    if (reset_n && imem_req && imem_ready) begin
      mq_addr.push_back(imem_addr);
      mq_due.push_back(cyc + int'($urandom_range(lat_max, lat_min)));
    end
    if (imem_rvalid) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    @(posedge clk);
    #1;
    cyc++;
    drive_mem();
    #1;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; redirect_valid = 1'b0; redirect_pc = 32'h0;
    out_ready = 1'b0; hold_ready = 1'b0;
    repeat (2) tick();
    mq_addr.delete();
    mq_due.delete();
    imem_rvalid = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", imem_req); end
    total++; if (imem_addr !== 32'h0) begin bad++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
    total++; if (out_instruction !== 32'h0) begin bad++; $display("FAIL rst_insn: got %h want 0", out_instruction); end
    total++; if (out_pc !== 32'h0) begin bad++; $display("FAIL rst_pc: got %h want 0", out_pc); end
    total++; if (out_pc_plus4 !== 32'h0) begin bad++; $display("FAIL rst_pc4: got %h want 0", out_pc_plus4); end
  endtask

  task automatic test_basic();
    int first_req = -1, first_out = -1;
    logic [31:0] reqs[$], outs[$], got;
    do_reset();
    lat_min = 1; lat_max = 1; ready_pct = 100; out_ready = 1'b1;
    reset_n = 1'b1; drive_mem(); #1;
    for (int i = 0; i < 9; i++) begin
      if (imem_req && imem_ready) begin
        if (first_req < 0) first_req = i;
        reqs.push_back(imem_addr);
      end
      if (out_valid && out_ready) begin
        if (first_out < 0) first_out = i;
        outs.push_back(out_pc);
        total++;
        if (out_instruction !== word_at(out_pc) || out_pc_plus4 !== out_pc + 32'd4) begin
          bad++; $display("FAIL basic_data: pc %h insn %h pc4 %h want insn %h pc4 %h",
                          out_pc, out_instruction, out_pc_plus4, word_at(out_pc), out_pc + 32'd4);
        end
      end
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      got = (k < reqs.size()) ? reqs[k] : 32'hDEAD_BEEF;
      total++; if (got !== 32'(k * 4)) begin bad++; $display("FAIL basic_req%0d: got %h want %h", k, got, 32'(k * 4)); end
      got = (k < outs.size()) ? outs[k] : 32'hDEAD_BEEF;
      total++; if (got !== 32'(k * 4)) begin bad++; $display("FAIL basic_out%0d: got %h want %h", k, got, 32'(k * 4)); end
    end
    total++;
    if (first_req < 0 || first_out !== first_req + 2) begin
      bad++; $display("FAIL basic_latency: first out cycle %0d want %0d", first_out, first_req + 2);
    end
  endtask

  task automatic test_stall();
    logic [31:0] reqs[$], outs[$], got;
    do_reset();
    lat_min = 1; lat_max = 1; ready_pct = 100;
    reset_n = 1'b1; drive_mem(); #1;
    repeat (6) tick();
    for (int i = 0; i < 3; i++) begin
      total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL stall_req: got %b want 0", imem_req); end
      total++;
      if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instruction !== word_at(32'h0)) begin
        bad++; $display("FAIL stall_hold: valid %b pc %h insn %h want 1 0 %h", out_valid, out_pc, out_instruction, word_at(32'h0));
      end
      tick();
    end
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (imem_req && imem_ready) reqs.push_back(imem_addr);
      if (out_valid && out_ready) outs.push_back(out_pc);
      tick();
    end
    got = (outs.size() > 0) ? outs[0] : 32'hDEAD_BEEF;
    total++; if (got !== 32'h0) begin bad++; $display("FAIL stall_drain0: got %h want 0", got); end
    got = (outs.size() > 1) ? outs[1] : 32'hDEAD_BEEF;
    total++; if (got !== 32'h4) begin bad++; $display("FAIL stall_drain1: got %h want 4", got); end
    got = (reqs.size() > 0) ? reqs[0] : 32'hDEAD_BEEF;
    total++; if (got !== 32'h8) begin bad++; $display("FAIL stall_resume: got %h want 8", got); end
  endtask

  task automatic test_redirect_wait();
    int n = 0;
    bit seen8 = 1'b0;
    logic [31:0] reqs[$], outs[$], got;
    do_reset();
    lat_min = 3; lat_max = 3; ready_pct = 100; out_ready = 1'b1;
    reset_n = 1'b1; drive_mem(); #1;
    while (!(imem_req && imem_ready && imem_addr == 32'h8) && n < 40) begin tick(); n++; end
    total++; if (n >= 40) begin bad++; $display("FAIL rdw_reach8: got timeout want request 8"); end
    tick();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (imem_req && imem_ready) reqs.push_back(imem_addr);
      if (out_valid && out_ready) begin
        outs.push_back(out_pc);
        if (out_pc == 32'h8) seen8 = 1'b1;
      end
      tick();
    end
    got = (reqs.size() > 0) ? reqs[0] : 32'hDEAD_BEEF;
    total++; if (got !== 32'h100) begin bad++; $display("FAIL rdw_req: got %h want 100", got); end
    got = (outs.size() > 0) ? outs[0] : 32'hDEAD_BEEF;
    total++; if (got !== 32'h100) begin bad++; $display("FAIL rdw_out: got %h want 100", got); end
    total++; if (seen8) begin bad++; $display("FAIL rdw_wrongpath: got pc 8 delivered want dropped"); end
  endtask

  task automatic test_redirect_rvalid();
    int n = 0;
    logic [31:0] got = 32'hDEAD_BEEF;
    do_reset();
    lat_min = 1; lat_max = 1; ready_pct = 100;
    reset_n = 1'b1; drive_mem(); #1;
    while (!(imem_rvalid && out_valid) && n < 20) begin tick(); n++; end
    total++; if (n >= 20) begin bad++; $display("FAIL rdr_setup: got timeout want rvalid with one word buffered"); end
    redirect_valid = 1'b1; redirect_pc = 32'h200;
    tick();
    redirect_valid = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rdr_flush: got %b want 0", out_valid); end
    total++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200) begin
      bad++; $display("FAIL rdr_addr: req %b addr %h want 1 200", imem_req, imem_addr);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (out_valid && got === 32'hDEAD_BEEF) got = out_pc;
      tick();
    end
    total++; if (got !== 32'h200) begin bad++; $display("FAIL rdr_out: got %h want 200", got); end
  endtask

  task automatic test_wrap();
    logic [31:0] reqs[$], outs[$], pc4s[$], got;
    do_reset();
    lat_min = 1; lat_max = 1; ready_pct = 100; out_ready = 1'b1;
    reset_n = 1'b1; drive_mem(); #1;
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (imem_req && imem_ready) reqs.push_back(imem_addr);
      if (out_valid && out_ready) begin outs.push_back(out_pc); pc4s.push_back(out_pc_plus4); end
      tick();
    end
    got = (reqs.size() > 1) ? reqs[1] : 32'hDEAD_BEEF;
    total++; if (got !== 32'h0) begin bad++; $display("FAIL wrap_req: got %h want 0", got); end
    got = (outs.size() > 0) ? outs[0] : 32'hDEAD_BEEF;
    total++; if (got !== 32'hFFFF_FFFC) begin bad++; $display("FAIL wrap_pc: got %h want fffffffc", got); end
    got = (pc4s.size() > 0) ? pc4s[0] : 32'hDEAD_BEEF;
    total++; if (got !== 32'h0) begin bad++; $display("FAIL wrap_pc4: got %h want 0", got); end
    redirect_valid = 1'b1; redirect_pc = 32'h103;
    tick();
    redirect_valid = 1'b0;
    reqs.delete();
    for (int i = 0; i < 10; i++) begin
      if (imem_req && imem_ready) reqs.push_back(imem_addr);
      tick();
    end
    got = (reqs.size() > 0) ? reqs[0] : 32'hDEAD_BEEF;
    total++; if (got !== 32'h100) begin bad++; $display("FAIL align_req: got %h want 100", got); end
  endtask

  task automatic test_reset_midop();
    logic [31:0] reqs[$], outs[$], insns[$], got;
    do_reset();
    lat_min = 3; lat_max = 3; ready_pct = 100; out_ready = 1'b1;
    reset_n = 1'b1; drive_mem(); #1;
    tick();
    reset_n = 1'b0; hold_ready = 1'b1; #1;
    total++; if (imem_req !== 1'b0) begin bad++; $display("FAIL mid_req: got %b want 0", imem_req); end
    tick();
    reset_n = 1'b1; #1;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_valid: got %b want 0", out_valid); end
    for (int i = 0; i < 3; i++) begin
      tick();
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL mid_late: got %b want 0", out_valid); end
    end
    hold_ready = 1'b0; imem_ready = 1'b1; #1;
    for (int i = 0; i < 10; i++) begin
      if (imem_req && imem_ready) reqs.push_back(imem_addr);
      if (out_valid && out_ready) begin outs.push_back(out_pc); insns.push_back(out_instruction); end
      tick();
    end
    got = (reqs.size() > 0) ? reqs[0] : 32'hDEAD_BEEF;
    total++; if (got !== 32'h0) begin bad++; $display("FAIL mid_restart: got %h want 0", got); end
    got = (outs.size() > 0) ? outs[0] : 32'hDEAD_BEEF;
    total++; if (got !== 32'h0) begin bad++; $display("FAIL mid_out: got %h want 0", got); end
    got = (insns.size() > 0) ? insns[0] : 32'hDEAD_BEEF;
    total++; if (got !== word_at(32'h0)) begin bad++; $display("FAIL mid_insn: got %h want %h", got, word_at(32'h0)); end
  endtask

  // Program-order model: requests and deliveries each walk +4 from the last redirect target.
  task automatic test_random();
    logic [31:0] exp_fetch = 32'h0, exp_out = 32'h0;
    int delivered = 0;
    do_reset();
    lat_min = 1; lat_max = 4; ready_pct = 70;
    reset_n = 1'b1; drive_mem(); #1;
    for (int i = 0; i < 3000; i++) begin
      out_ready      = (int'($urandom_range(99)) < 75);
      redirect_valid = (int'($urandom_range(99)) < 4);
      redirect_pc    = $urandom;
      if (imem_req && imem_ready) begin
        total++;
        if (imem_addr !== exp_fetch) begin bad++; $display("FAIL rnd_req: got %h want %h", imem_addr, exp_fetch); end
        exp_fetch = exp_fetch + 32'd4;
      end
      if (out_valid && out_ready && !redirect_valid) begin
        total++;
        if (out_pc !== exp_out || out_instruction !== word_at(exp_out) || out_pc_plus4 !== exp_out + 32'd4) begin
          bad++; $display("FAIL rnd_out: got pc %h insn %h pc4 %h want %h %h %h",
                          out_pc, out_instruction, out_pc_plus4, exp_out, word_at(exp_out), exp_out + 32'd4);
        end
        exp_out = exp_out + 32'd4;
        delivered++;
      end
      if (redirect_valid) begin
        exp_fetch = redirect_pc & 32'hFFFF_FFFC;
        exp_out   = redirect_pc & 32'hFFFF_FFFC;
      end
      tick();
    end
    redirect_valid = 1'b0;
    total++; if (delivered < 200) begin bad++; $display("FAIL rnd_progress: got %0d deliveries want >= 200", delivered); end
  endtask

  initial begin
    reset_n = 1'b0; imem_ready = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b0;
    test_reset();
    test_basic();
    test_stall();
    test_redirect_wait();
    test_redirect_rvalid();
    test_wrap();
    test_reset_midop();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
